bcd_up_2d: RTL and testbench
============================

BCD_UP_2D -- requirements
Module: bcd_up_2d

Interface
REQ-001 Parameter BCD_BIT_WIDTH, default 4: width of each BCD digit.
REQ-002 clk  input  1: single clock; all state updates on rising edge.
REQ-003 rst  input  1: one clock; reset is synchronous and active-high.
REQ-004 en  input  1: count enable, sampled each cycle; one increment per cycle it is high in RUN.
REQ-005 start  input  1: start/restart request, sampled each cycle.
REQ-006 clr  input  1: synchronous clear to 00 and IDLE.
REQ-007 lim0  input  BCD_BIT_WIDTH: target ones digit (BCD).
REQ-008 lim1  input  BCD_BIT_WIDTH: target tens digit (BCD).
REQ-009 val0  output  BCD_BIT_WIDTH: current ones digit.
REQ-010 val1  output  BCD_BIT_WIDTH: current tens digit.
REQ-011 done  output  1: high while in DONE.
REQ-012 busy  output  1: high while in RUN.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE: val1:val0 = 00; start=1 latches lim1:lim0 into target register and enters RUN next cycle.
REQ-015 Latched digits >9 SHALL be clamped to 9 at latch time.
REQ-016 Target 00 latched: state SHALL go IDLE -> DONE directly, value stays 00.
REQ-017 RUN: each cycle with en=1, value increments by 1 in BCD; val0 wraps 9->0 with carry into val1.
REQ-018 Increment latency: value updates on the clk edge ending the en=1 cycle (1 cycle).
REQ-019 When the incremented value equals target, state enters DONE on the same edge the value updates; done and the final value appear together.
REQ-020 DONE: value holds at target; en ignored.
REQ-021 start in DONE: value -> 00 and new target latched on next edge; state -> RUN (or DONE if new target is 00).
REQ-022 start in RUN SHALL be ignored; target not re-latched.
REQ-023 en in IDLE SHALL be ignored.
REQ-024 clr=1 in any state: next edge value = 00, state = IDLE; clr has priority over start and en.
REQ-025 Value SHALL never exceed target and never exceed 99; no 99->00 wrap.
REQ-026 lim0/lim1 changes after latch SHALL not affect the current run.
REQ-027 All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 at a clk edge: state IDLE, val0=0, val1=0, target=00, done=0, busy=0.
REQ-029 rst SHALL have priority over clr, start, en, including mid-run.
REQ-030 First cycle after rst deasserts SHALL accept start.

Structure
REQ-031 Shared defines header holds BCD_BIT_WIDTH, ENABLED/DISABLED, BCD digit max (9), and FSM state encodings.
REQ-032 One sub-module, upcounter: single BCD digit with increase, carry, limit, synchronous active-high reset and clear; instantiated twice, ones-digit carry drives tens-digit increase.
REQ-033 Top level holds the FSM, target register and equality compare.

Verification
REQ-034 rst, start with lim=30, en high 30 cycles -> val steps 00..30, done rises with val=30 on 30th edge, busy falls same edge.
REQ-035 lim=09, en=1 for 9 cycles then 5 more -> val held 09, done=1; val0 9->0 carry checked with lim=15 (09 -> 10).
REQ-036 lim=00, start -> DONE next edge, val=00, busy never high.
REQ-037 lim=1C (tens=1, ones=12) -> clamped target 19; count stops at 19.
REQ-038 Mid-run at val=17: clr and en together -> next edge val=00, IDLE; repeat with rst -> same; start during RUN with new lim -> ignored.
REQ-039 DONE at 30, start with lim=05 -> val=00 then counts to 05, done asserted at 05.

Source files
------------

// File: rtl/bcd_up_2d_pkg.sv
// ============================================================================
// Module      : bcd_up_2d_pkg
// Description : Shared constants and FSM state encoding for the 2-digit BCD
//               up-counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package bcd_up_2d_pkg;

  localparam int   DEF_BCD_BIT_WIDTH = 4;
  localparam logic ENABLED           = 1'b1;
  localparam logic DISABLED          = 1'b0;
  localparam int   BCD_DIGIT_MAX     = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_up_2d_upcounter.sv
// ============================================================================
// Module      : bcd_up_2d_upcounter
// Description : Single BCD digit with increase/carry, wrap at lim, sync clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bcd_up_2d_upcounter
  import bcd_up_2d_pkg::*;
#(
  parameter int BCD_BIT_WIDTH = DEF_BCD_BIT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  input  logic [BCD_BIT_WIDTH-1:0] lim,
  output logic [BCD_BIT_WIDTH-1:0] val,
  output logic                     carry
);

  localparam logic [BCD_BIT_WIDTH-1:0] ONE = BCD_BIT_WIDTH'(1);

  logic [BCD_BIT_WIDTH-1:0] val_q;
  logic [BCD_BIT_WIDTH-1:0] val_d;

  always_comb begin
    val_d = val_q;
    carry = DISABLED;
    if (inc == ENABLED) begin
      if (val_q == lim) begin
        val_d = '0;
        carry = ENABLED;
      end else begin
        val_d = val_q + ONE;
      end
    end
    if (clr == ENABLED) begin
      val_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val = val_q;

endmodule

`default_nettype wire

// File: rtl/bcd_up_2d.sv
// ============================================================================
// Module      : bcd_up_2d
// Description : Two-digit BCD up-counter that runs from 00 to a latched target.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bcd_up_2d
  import bcd_up_2d_pkg::*;
#(
  parameter int BCD_BIT_WIDTH = DEF_BCD_BIT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic                     clr,
  input  logic [BCD_BIT_WIDTH-1:0] lim0,
  input  logic [BCD_BIT_WIDTH-1:0] lim1,
  output logic [BCD_BIT_WIDTH-1:0] val0,
  output logic [BCD_BIT_WIDTH-1:0] val1,
  output logic                     done,
  output logic                     busy
);

  localparam logic [BCD_BIT_WIDTH-1:0] DIGIT_MAX = BCD_BIT_WIDTH'(BCD_DIGIT_MAX);
  localparam logic [BCD_BIT_WIDTH-1:0] ONE       = BCD_BIT_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [BCD_BIT_WIDTH-1:0] tgt0_q, tgt0_d;
  logic [BCD_BIT_WIDTH-1:0] tgt1_q, tgt1_d;

  logic [BCD_BIT_WIDTH-1:0] lim0_c, lim1_c;
  logic [BCD_BIT_WIDTH-1:0] nxt0, nxt1;
  logic                     lim_zero;
  logic                     inc0, carry0, cnt_clr;
  logic                     tens_carry_unused;

  assign lim0_c   = (lim0 > DIGIT_MAX) ? DIGIT_MAX : lim0;
  assign lim1_c   = (lim1 > DIGIT_MAX) ? DIGIT_MAX : lim1;
  assign lim_zero = (lim0_c == '0) && (lim1_c == '0);

  // Value after one increment, used to hit DONE on the same edge as the count.
  assign nxt0 = (val0 == DIGIT_MAX) ? '0 : (val0 + ONE);
  assign nxt1 = (val0 == DIGIT_MAX) ? (val1 + ONE) : val1;

  always_comb begin
    state_d = state_q;
    tgt0_d  = tgt0_q;
    tgt1_d  = tgt1_q;
    inc0    = DISABLED;
    cnt_clr = clr;
    case (state_q)
      ST_IDLE: begin
        if (start == ENABLED) begin
          tgt0_d  = lim0_c;
          tgt1_d  = lim1_c;
          state_d = lim_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (en == ENABLED) begin
          inc0 = ENABLED;
          if ((nxt1 == tgt1_q) && (nxt0 == tgt0_q)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (start == ENABLED) begin
          tgt0_d  = lim0_c;
          tgt1_d  = lim1_c;
          cnt_clr = ENABLED;
          state_d = lim_zero ? ST_DONE : ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr == ENABLED) begin
      state_d = ST_IDLE;
      inc0    = DISABLED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt0_q  <= '0;
      tgt1_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt0_q  <= tgt0_d;
      tgt1_q  <= tgt1_d;
    end
  end

  bcd_up_2d_upcounter #(
    .BCD_BIT_WIDTH (BCD_BIT_WIDTH)
  ) u_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (inc0),
    .lim   (DIGIT_MAX),
    .val   (val0),
    .carry (carry0)
  );

  bcd_up_2d_upcounter #(
    .BCD_BIT_WIDTH (BCD_BIT_WIDTH)
  ) u_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (carry0),
    .lim   (DIGIT_MAX),
    .val   (val1),
    .carry (tens_carry_unused)
  );

  assign done = (state_q == ST_DONE);
  assign busy = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_bcd_up_2d.sv
// ============================================================================
// Module      : tb_bcd_up_2d
// Description : Self-checking bench for bcd_up_2d (vector table + decimal model).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_up_2d;

  localparam int W = 4;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         start = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] lim0 = '0;
  logic [W-1:0] lim1 = '0;
  logic [W-1:0] val0, val1;
  logic         done, busy;

  always #5 clk = ~clk;

  bcd_up_2d #(.BCD_BIT_WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .clr   (clr),
    .lim0  (lim0),
    .lim1  (lim1),
    .val0  (val0),
    .val1  (val1),
    .done  (done),
    .busy  (busy)
  );

  typedef struct {
    logic         r, c, s, e;
    logic [W-1:0] l0, l1;
    logic [W-1:0] e0, e1;
    logic         ed, eb;
  } vec_t;

  typedef struct {
    logic [W-1:0] v0, v1;
    logic         d, b;
    string        name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[11];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_st = S_IDLE;
  int m_cnt = 0;
  int m_tgt = 0;

  function automatic vec_t mk(logic r, logic c, logic s, logic e, int l1, int l0,
                              int e1, int e0, logic ed, logic eb);
    vec_t v;
    v.r = r; v.c = c; v.s = s; v.e = e;
    v.l0 = W'(l0); v.l1 = W'(l1);
    v.e0 = W'(e0); v.e1 = W'(e1);
    v.ed = ed; v.eb = eb;
    return v;
  endfunction

  function automatic int clamp_lim(logic [W-1:0] a1, logic [W-1:0] a0);
    int t1, t0;
    t1 = (int'(a1) > 9) ? 9 : int'(a1);
    t0 = (int'(a0) > 9) ? 9 : int'(a0);
    return t1 * 10 + t0;
  endfunction

  // Decimal reference of the counter behaviour.
  task automatic model_step(input vec_t v);
    if (v.r) begin
      m_st = S_IDLE; m_cnt = 0; m_tgt = 0;
    end else if (v.c) begin
      m_st = S_IDLE; m_cnt = 0;
    end else begin
      case (m_st)
        S_IDLE: if (v.s) begin
          m_tgt = clamp_lim(v.l1, v.l0);
          m_st  = (m_tgt == 0) ? S_DONE : S_RUN;
        end
        S_RUN: if (v.e) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == m_tgt) m_st = S_DONE;
        end
        default: if (v.s) begin
          m_cnt = 0;
          m_tgt = clamp_lim(v.l1, v.l0);
          m_st  = (m_tgt == 0) ? S_DONE : S_RUN;
        end
      endcase
    end
  endtask

  task automatic cycle(input vec_t v, input bit from_table, input string nm);
    exp_t x;
    rst = v.r; clr = v.c; start = v.s; en = v.e; lim0 = v.l0; lim1 = v.l1;
    model_step(v);
    if (from_table) begin
      x.v0 = v.e0; x.v1 = v.e1; x.d = v.ed; x.b = v.eb;
    end else begin
      x.v0 = W'(m_cnt % 10); x.v1 = W'(m_cnt / 10);
      x.d = (m_st == S_DONE); x.b = (m_st == S_RUN);
    end
    x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_out();
    exp_t x;
    x = sb.pop_front();
    n_cmp++;
    if ({val1, val0, done, busy} !== {x.v1, x.v0, x.d, x.b}) begin
      n_bad++;
      $display("FAIL %s: got val=%h%h done=%b busy=%b, expected val=%h%h done=%b busy=%b",
               x.name, val1, val0, done, busy, x.v1, x.v0, x.d, x.b);
    end
  endtask

  task automatic op(input logic r, c, s, e, input int l1, l0, input string nm);
    cycle(mk(r, c, s, e, l1, l0, 0, 0, 1'b0, 1'b0), 1'b0, nm);
  endtask

  task automatic count(input int n, input string nm);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, nm);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0,   0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 2,   0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 1, 0, 0,   0, 1, 0, 1);
    tbl[5]  = mk(0, 0, 1, 1, 0, 9,   0, 2, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0,   0, 2, 1, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 1, 12,  0, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 1, 0, 0,   0, 1, 0, 1);

    #1;
    for (int i = 0; i < 11; i++) cycle(tbl[i], 1'b1, $sformatf("table_row%0d", i));

    // Count to 30, then hold.
    op(1, 0, 0, 0, 0, 0, "rst_a");
    op(0, 0, 1, 0, 3, 0, "start_30");
    count(30, "count_to_30");
    count(5, "hold_30");

    // Single-digit target and ones->tens carry.
    op(1, 0, 0, 0, 0, 0, "rst_b");
    op(0, 0, 1, 0, 0, 9, "start_09");
    count(14, "count_09_hold");
    op(1, 0, 0, 0, 0, 0, "rst_c");
    op(0, 0, 1, 0, 1, 5, "start_15");
    count(16, "carry_to_15");

    // Zero target goes straight to DONE.
    op(1, 0, 0, 0, 0, 0, "rst_d");
    op(0, 0, 1, 1, 0, 0, "start_00");
    count(3, "hold_00");

    // Clamped target 1C -> 19.
    op(1, 0, 0, 0, 0, 0, "rst_e");
    op(0, 0, 1, 0, 1, 12, "start_1c");
    count(25, "clamp_19");

    // Mid-run clr, mid-run rst, start ignored during RUN.
    op(0, 1, 0, 0, 0, 0, "clr_e");
    op(0, 0, 1, 0, 2, 5, "start_25a");
    count(17, "run_to_17a");
    op(0, 1, 1, 1, 2, 5, "clr_mid");
    op(0, 0, 1, 0, 2, 5, "start_25b");
    count(17, "run_to_17b");
    op(1, 1, 1, 1, 2, 5, "rst_mid");
    op(0, 0, 1, 0, 1, 9, "start_19");
    count(5, "run_to_05");
    op(0, 0, 1, 1, 0, 3, "start_in_run");
    count(16, "run_to_19");

    // Restart from DONE at 30 with new target 05.
    op(1, 0, 0, 0, 0, 0, "rst_f");
    op(0, 0, 1, 0, 3, 0, "start_30b");
    count(30, "count_to_30b");
    op(0, 0, 1, 1, 0, 5, "restart_05");
    count(7, "count_to_05");

    // Maximum target, no wrap past 99.
    op(1, 0, 0, 0, 0, 0, "rst_g");
    op(0, 0, 1, 0, 15, 15, "start_99");
    count(105, "count_to_99");

    // Random traffic against the model.
    op(1, 0, 0, 0, 0, 0, "rst_h");
    for (int i = 0; i < 400; i++) begin
      op(($urandom % 64) == 0, ($urandom % 32) == 0, ($urandom % 8) == 0,
         ($urandom % 4) != 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
